// File: rtl/flag_generator_blocked_ordered_if.sv
// Stream bundle for the flag generator: raw sample input and flagged output.
// The slave modport is the generator's view; master is the environment's view.
interface flag_generator_blocked_ordered_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] raw_input_data;
   logic                  raw_input_valid;
   logic                  raw_input_ready;
   logic [DATA_WIDTH-1:0] output_data;
   logic                  output_valid;
   logic                  output_ready;
   logic                  output_last_s;
   logic                  output_last_r;
   logic                  output_last_b;
   logic                  output_last_i;

   modport slave (
      input  raw_input_data, raw_input_valid, output_ready,
      output raw_input_ready, output_data, output_valid,
      output output_last_s, output_last_r, output_last_b, output_last_i
   );

   modport master (
      output raw_input_data, raw_input_valid, output_ready,
      input  raw_input_ready, output_data, output_valid,
      input  output_last_s, output_last_r, output_last_b, output_last_i
   );
endinterface

// File: rtl/flag_generator_blocked_ordered.sv
// Tags a raster sample stream with sample/row/band/image flags for a blocked
// traversal in band-sequential or band-interleaved order, behind skid stages.
module flag_generator_blocked_ordered_skid #(
   parameter int WIDTH  = 1,
   parameter bit ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   if (ENABLE) begin : g_reg
      logic [WIDTH-1:0] main_data, skid_data;
      logic             main_valid, skid_valid;

      // NOTE: only the valid bits are reset; data registers are don't-care while their valid is low.
      always_ff @(posedge clk) begin
         if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
               main_data  <= skid_data;
               main_valid <= 1'b1;
               skid_valid <= 1'b0;
            end else begin
               main_data  <= in_data;
               main_valid <= in_valid;
            end
         end else if (in_valid && !skid_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
         end
      end

      assign in_ready  = !skid_valid;
      assign out_data  = main_data;
      assign out_valid = main_valid;
   end else begin : g_bypass
      assign in_ready  = out_ready;
      assign out_data  = in_data;
      assign out_valid = in_valid;
   end
endmodule

module flag_generator_blocked_ordered #(
   parameter int DATA_WIDTH           = 16,
   parameter int MAX_BLOCK_SAMPLE_LOG = 4,
   parameter int MAX_BLOCK_LINE_LOG   = 4,
   parameter int MAX_IMAGE_SAMPLE_LOG = 12,
   parameter int MAX_IMAGE_LINE_LOG   = 12,
   parameter int MAX_IMAGE_BAND_LOG   = 12,
   parameter bit LATCH_INPUT          = 1'b1,
   parameter bit LATCH_OUTPUT         = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
   input  logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
   input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
   input  logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
   input  logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,
   input  logic                            config_order,
   flag_generator_blocked_ordered_if.slave bus
);
   localparam int BS = MAX_BLOCK_SAMPLE_LOG;
   localparam int BL = MAX_BLOCK_LINE_LOG;
   localparam int IS = MAX_IMAGE_SAMPLE_LOG;
   localparam int IL = MAX_IMAGE_LINE_LOG;
   localparam int IB = MAX_IMAGE_BAND_LOG;
   localparam int PW = DATA_WIDTH + 4;

   logic          active;
   logic [BS-1:0] cap_blk_s, cfg_blk_s, s_cnt, s_nxt;
   logic [BL-1:0] cap_blk_l, cfg_blk_l, l_cnt, l_nxt;
   logic [IS-1:0] cap_img_s, cfg_img_s, sample_base, sample_base_nxt, rem_s, blk_w_m1;
   logic [IL-1:0] cap_img_l, cfg_img_l, line_base, line_base_nxt, rem_l, blk_h_m1;
   logic [IB-1:0] cap_img_b, cfg_img_b, b_cnt, b_nxt;
   logic          cap_order, cfg_order;
   logic          s_last, l_last, b_last, col_last, row_last;
   logic          step_s, step_l, step_b, step_blk;
   logic [3:0]    flags;  // {last_i, last_b, last_r, last_s}
   logic          accept, stage_ready, mid_valid, mid_ready;
   logic [PW-1:0] mid_data, out_payload;

   // The first word of an image sees the live config; later words the captured copy.
   assign cfg_blk_s = active ? cap_blk_s : config_block_samples;
   assign cfg_blk_l = active ? cap_blk_l : config_block_lines;
   assign cfg_img_s = active ? cap_img_s : config_image_samples;
   assign cfg_img_l = active ? cap_img_l : config_image_lines;
   assign cfg_img_b = active ? cap_img_b : config_image_bands;
   assign cfg_order = active ? cap_order : config_order;

   assign bus.raw_input_ready = stage_ready & ~rst;
   assign accept              = bus.raw_input_valid & bus.raw_input_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rem_s    = cfg_img_s - sample_base;
      rem_l    = cfg_img_l - line_base;
      col_last = rem_s <= IS'(cfg_blk_s);
      row_last = rem_l <= IL'(cfg_blk_l);
      blk_w_m1 = col_last ? rem_s : IS'(cfg_blk_s);
      blk_h_m1 = row_last ? rem_l : IL'(cfg_blk_l);
      s_last   = IS'(s_cnt) == blk_w_m1;
      l_last   = IL'(l_cnt) == blk_h_m1;
      b_last   = b_cnt == cfg_img_b;

      flags = 4'b0000;
      if (!cfg_order) begin
         flags[0] = s_last;
         flags[1] = flags[0] & l_last;
         flags[2] = flags[1] & b_last;
         flags[3] = flags[2] & col_last & row_last;
         step_s   = 1'b1;
         step_l   = s_last;
         step_b   = s_last & l_last;
         step_blk = step_b & b_last;
      end else begin
         flags[2] = b_last;
         flags[0] = flags[2] & s_last;
         flags[1] = flags[0] & l_last;
         flags[3] = flags[1] & col_last & row_last;
         step_b   = 1'b1;
         step_s   = b_last;
         step_l   = b_last & s_last;
         step_blk = step_l & l_last;
      end

      s_nxt           = s_cnt;
      l_nxt           = l_cnt;
      b_nxt           = b_cnt;
      sample_base_nxt = sample_base;
      line_base_nxt   = line_base;
      if (step_s) s_nxt = s_last ? '0 : s_cnt + 1'b1;
      if (step_l) l_nxt = l_last ? '0 : l_cnt + 1'b1;
      if (step_b) b_nxt = b_last ? '0 : b_cnt + 1'b1;
      if (step_blk) begin
         sample_base_nxt = col_last ? '0 : sample_base + IS'(cfg_blk_s) + 1'b1;
         if (col_last) line_base_nxt = row_last ? '0 : line_base + IL'(cfg_blk_l) + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         active      <= 1'b0;
         s_cnt       <= '0;
         l_cnt       <= '0;
         b_cnt       <= '0;
         sample_base <= '0;
         line_base   <= '0;
      end else if (accept) begin
         s_cnt       <= s_nxt;
         l_cnt       <= l_nxt;
         b_cnt       <= b_nxt;
         sample_base <= sample_base_nxt;
         line_base   <= line_base_nxt;
         active      <= ~flags[3];
         if (!active) begin
            cap_blk_s <= config_block_samples;
            cap_blk_l <= config_block_lines;
            cap_img_s <= config_image_samples;
            cap_img_l <= config_image_lines;
            cap_img_b <= config_image_bands;
            cap_order <= config_order;
         end
      end
   end

   flag_generator_blocked_ordered_skid #(.WIDTH(PW), .ENABLE(LATCH_INPUT)) u_in_stage (
      .clk(clk), .rst(rst),
      .in_data({flags, bus.raw_input_data}), .in_valid(bus.raw_input_valid), .in_ready(stage_ready),
      .out_data(mid_data), .out_valid(mid_valid), .out_ready(mid_ready)
   );

   flag_generator_blocked_ordered_skid #(.WIDTH(PW), .ENABLE(LATCH_OUTPUT)) u_out_stage (
      .clk(clk), .rst(rst),
      .in_data(mid_data), .in_valid(mid_valid), .in_ready(mid_ready),
      .out_data(out_payload), .out_valid(bus.output_valid), .out_ready(bus.output_ready)
   );

   assign bus.output_data   = out_payload[DATA_WIDTH-1:0];
   assign bus.output_last_s = out_payload[DATA_WIDTH]   & bus.output_valid;
   assign bus.output_last_r = out_payload[DATA_WIDTH+1] & bus.output_valid;
   assign bus.output_last_b = out_payload[DATA_WIDTH+2] & bus.output_valid;
   assign bus.output_last_i = out_payload[DATA_WIDTH+3] & bus.output_valid;
endmodule

// File: tb/tb_flag_generator_blocked_ordered.sv
// Directed bench for flag_generator_blocked_ordered: ramp images through both
// traversal orders, stalls, mid-image config change, reset, degenerate sizes.
module tb_flag_generator_blocked_ordered;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  cfg_blk_s = 4'd2;
   logic [3:0]  cfg_blk_l = 4'd2;
   logic [11:0] cfg_img_s = 12'd6;
   logic [11:0] cfg_img_l = 12'd6;
   logic [11:0] cfg_img_b = 12'd2;
   logic        cfg_order = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          ready_pct = 100;
   int          out_count = 0;
   logic [19:0] exp_q[$];
   logic [3:0]  obs_flags[0:511];

   flag_generator_blocked_ordered_if #(.DATA_WIDTH(16)) bus ();

   flag_generator_blocked_ordered dut (
      .clk(clk), .rst(rst),
      .config_block_samples(cfg_blk_s), .config_block_lines(cfg_blk_l),
      .config_image_samples(cfg_img_s), .config_image_lines(cfg_img_l),
      .config_image_bands(cfg_img_b), .config_order(cfg_order),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected word list built from nested loops over blocks (sizes, not size-1).
   function automatic void push_exp(int idx, bit s, bit r, bit b, bit i);
      exp_q.push_back({i, b, r, s, 16'(idx)});
   endfunction

   task automatic build_expected(input int is, input int il, input int ib,
                                 input int bs, input int bl, input bit order);
      int idx = 0;
      int w, h;
      bit lb, s, r, b;
      for (int y0 = 0; y0 < il; y0 += bl) begin
         for (int x0 = 0; x0 < is; x0 += bs) begin
            w  = (is - x0 < bs) ? is - x0 : bs;
            h  = (il - y0 < bl) ? il - y0 : bl;
            lb = (x0 + w == is) && (y0 + h == il);
            if (!order) begin
               for (int bb = 0; bb < ib; bb++)
                  for (int y = 0; y < h; y++)
                     for (int x = 0; x < w; x++) begin
                        s = (x == w - 1);
                        r = s && (y == h - 1);
                        b = r && (bb == ib - 1);
                        push_exp(idx++, s, r, b, b && lb);
                     end
            end else begin
               for (int y = 0; y < h; y++)
                  for (int x = 0; x < w; x++)
                     for (int bb = 0; bb < ib; bb++) begin
                        b = (bb == ib - 1);
                        s = b && (x == w - 1);
                        r = s && (y == h - 1);
                        push_exp(idx++, s, r, b, r && lb);
                     end
            end
         end
      end
   endtask

   task automatic send_word(input logic [15:0] d, input int gap_pct);
      bit done = 1'b0;
      int budget = 500;
      while ($urandom_range(99) < gap_pct) begin
         bus.raw_input_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.raw_input_data  = d;
      bus.raw_input_valid = 1'b1;
      while (!done && budget > 0) begin
         @(negedge clk);
         done = bus.raw_input_ready;
         @(posedge clk); #1;
         budget--;
      end
      if (!done) check("accept_timeout", 32'(done), 1);
   endtask

   task automatic send_image(input int n, input int gap_pct, input int change_at);
      for (int i = 0; i < n; i++) begin
         if (i == change_at) cfg_blk_s = 4'd1;
         send_word(16'(i), gap_pct);
      end
      bus.raw_input_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int budget = 5000;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check(tag, 32'(exp_q.size()), 0);
      repeat (5) @(posedge clk);
      #1;
   endtask

   // Downstream ready with a configurable acceptance probability.
   initial begin
      bus.output_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.output_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // Output monitor: scoreboard compare plus hold-while-stalled check.
   initial begin
      logic [19:0] cur, held, e;
      bit stalled = 1'b0;
      forever begin
         @(negedge clk);
         cur = {bus.output_last_i, bus.output_last_b, bus.output_last_r, bus.output_last_s,
                bus.output_data};
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", 32'(bus.output_valid), 1);
               check("stall_hold", 32'(cur), 32'(held));
            end
            if (bus.output_valid && bus.output_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_word", 32'(exp_q.size()), 1);
               end else begin
                  e = exp_q.pop_front();
                  check("word", 32'(cur), 32'(e));
               end
               if (out_count < 512) obs_flags[out_count] = cur[19:16];
               out_count++;
            end
            stalled = bus.output_valid && !bus.output_ready;
            held    = cur;
         end
      end
   end

   initial begin
      bus.raw_input_valid = 1'b0;
      bus.raw_input_data  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.output_valid), 0);
      check("rst_ready", 32'(bus.raw_input_ready), 0);
      check("rst_flags", {28'd0, bus.output_last_i, bus.output_last_b, bus.output_last_r,
                          bus.output_last_s}, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.raw_input_ready), 1);

      // Scenario 1 + 3: 7x7x3, block 3x3, band-sequential, free drain
      out_count = 0;
      build_expected(7, 7, 3, 3, 3, 1'b0);
      send_image(147, 0, -1);
      wait_drain("s1_drain");
      check("s1_count", 32'(out_count), 147);
      check("s1_idx2", 32'(obs_flags[2]), 32'h1);
      check("s1_idx8", 32'(obs_flags[8]), 32'h3);
      check("s1_idx26", 32'(obs_flags[26]), 32'h7);
      check("s1_idx146", 32'(obs_flags[146]), 32'hf);
      check("s3_idx54", 32'(obs_flags[54]), 32'h1);
      check("s3_idx56", 32'(obs_flags[56]), 32'h3);
      check("s3_idx57", 32'(obs_flags[57]), 32'h1);
      check("s3_idx62", 32'(obs_flags[62]), 32'h7);

      // Scenario 2: band-interleaved
      cfg_order = 1'b1;
      out_count = 0;
      build_expected(7, 7, 3, 3, 3, 1'b1);
      send_image(147, 0, -1);
      wait_drain("s2_drain");
      check("s2_count", 32'(out_count), 147);
      check("s2_idx0", 32'(obs_flags[0]), 32'h0);
      check("s2_idx2", 32'(obs_flags[2]), 32'h4);
      check("s2_idx8", 32'(obs_flags[8]), 32'h5);
      check("s2_idx26", 32'(obs_flags[26]), 32'h7);
      check("s2_idx146", 32'(obs_flags[146]), 32'hf);

      // Scenario 4: random valid and ready gaps
      cfg_order = 1'b0;
      ready_pct = 50;
      out_count = 0;
      build_expected(7, 7, 3, 3, 3, 1'b0);
      send_image(147, 50, -1);
      wait_drain("s4_drain");
      check("s4_count", 32'(out_count), 147);
      ready_pct = 100;

      // Scenario 5: block width changed mid-image, takes effect on next image
      out_count = 0;
      build_expected(7, 7, 3, 3, 3, 1'b0);
      build_expected(7, 7, 3, 2, 3, 1'b0);
      send_image(147, 0, 40);
      send_image(147, 0, -1);
      wait_drain("s5_drain");
      check("s5_count", 32'(out_count), 294);
      check("s5_img1_idx2", 32'(obs_flags[2]), 32'h1);
      check("s5_img1_idx146", 32'(obs_flags[146]), 32'hf);
      check("s5_img2_idx0", 32'(obs_flags[147]), 32'h0);
      check("s5_img2_idx1", 32'(obs_flags[148]), 32'h1);
      check("s5_img2_idx3", 32'(obs_flags[150]), 32'h1);
      cfg_blk_s = 4'd2;

      // Scenario 6: reset at word 60, then restart
      build_expected(7, 7, 3, 3, 3, 1'b0);
      send_image(60, 0, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("s6_valid_after_rst", 32'(bus.output_valid), 0);
      check("s6_ready_in_rst", 32'(bus.raw_input_ready), 0);
      exp_q.delete();
      rst = 1'b0;
      out_count = 0;
      build_expected(7, 7, 3, 3, 3, 1'b0);
      send_image(147, 0, -1);
      wait_drain("s6_drain");
      check("s6_count", 32'(out_count), 147);
      check("s6_idx146", 32'(obs_flags[146]), 32'hf);

      // All-zero config: every word is a whole image
      cfg_blk_s = '0; cfg_blk_l = '0; cfg_img_s = '0; cfg_img_l = '0; cfg_img_b = '0;
      out_count = 0;
      for (int k = 0; k < 3; k++) build_expected(1, 1, 1, 1, 1, 1'b0);
      for (int k = 0; k < 3; k++) send_image(1, 0, -1);
      wait_drain("zero_drain");
      check("zero_count", 32'(out_count), 3);
      check("zero_w0", 32'(obs_flags[0]), 32'hf);
      check("zero_w2", 32'(obs_flags[2]), 32'hf);

      // Block larger than image: 2x3x2 image, block 16x16, band-interleaved
      cfg_blk_s = 4'd15; cfg_blk_l = 4'd15;
      cfg_img_s = 12'd1; cfg_img_l = 12'd2; cfg_img_b = 12'd1; cfg_order = 1'b1;
      out_count = 0;
      build_expected(2, 3, 2, 16, 16, 1'b1);
      send_image(12, 0, -1);
      wait_drain("big_drain");
      check("big_count", 32'(out_count), 12);
      check("big_idx1", 32'(obs_flags[1]), 32'h4);
      check("big_idx3", 32'(obs_flags[3]), 32'h5);
      check("big_idx11", 32'(obs_flags[11]), 32'hf);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/flag_generator_blocked_ordered.md
FLAG_GENERATOR_BLOCKED_ORDERED -- requirements
Module: flag_generator_blocked_ordered

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the sample data.
REQ-002 Parameters MAX_BLOCK_SAMPLE_LOG, MAX_BLOCK_LINE_LOG, defaults 4, 4, SHALL set the widths of the block config ports.
REQ-003 Parameters MAX_IMAGE_SAMPLE_LOG, MAX_IMAGE_LINE_LOG, MAX_IMAGE_BAND_LOG, defaults 12, 12, 12, SHALL set the widths of the image config ports.
REQ-004 Parameters LATCH_INPUT, LATCH_OUTPUT, defaults 1, 1, SHALL each enable (1) or bypass (0) one registered skid stage.
REQ-005 Ports: clk in 1, rising-edge clock; rst in 1, reset. There is one clock; reset is synchronous and active-high.
REQ-006 Ports: config_block_samples in MAX_BLOCK_SAMPLE_LOG and config_block_lines in MAX_BLOCK_LINE_LOG, block size minus one.
REQ-007 Ports: config_image_samples in MAX_IMAGE_SAMPLE_LOG, config_image_lines in MAX_IMAGE_LINE_LOG and config_image_bands in MAX_IMAGE_BAND_LOG, image size minus one.
REQ-008 Port: config_order in 1, traversal order; 0 = band-sequential per block, 1 = band-interleaved per block.
REQ-009 Ports: raw_input_data in DATA_WIDTH, raw_input_valid in 1 and raw_input_ready out 1, AXI-Stream style slave.
REQ-010 Ports: output_data out DATA_WIDTH, output_valid out 1 and output_ready in 1, AXI-Stream style master.
REQ-011 Ports: output_last_s, output_last_r, output_last_b and output_last_i, each out 1; these are the sample, row, band and image flags, qualified by output_valid.

Function
REQ-012 Blocks SHALL be visited in raster order: block columns left to right, then block rows top to bottom.
REQ-013 Edge blocks SHALL be truncated. Width = min(config_block_samples+1, image samples remaining from the block origin). Height is computed the same way from lines.
REQ-014 Mode 0 ordering: within a block, the loop order from fastest to slowest SHALL be sample, line, band.
REQ-015 Mode 0 flags: last_s = last sample of the block row; last_r = last_s and last block line; last_b = last_r and last band; last_i = last_b and last block.
REQ-016 Mode 1 ordering: within a block, the loop order from fastest to slowest SHALL be band, sample, line.
REQ-017 Mode 1 flags: last_b = last band; last_s = last_b and last block sample; last_r = last_s and last block line; last_i = last_r and last block.
REQ-018 Flags SHALL be computed from the counters at input acceptance (raw_input_valid and raw_input_ready) and SHALL travel with that word.
REQ-019 Counters SHALL advance only on input acceptance. A stalled input SHALL leave the counters unchanged.
REQ-020 Config and config_order SHALL be captured at the first acceptance of an image. They SHALL be held until the word carrying last_i is accepted.
REQ-021 After the last_i word is accepted, all counters SHALL wrap to zero. The next acceptance SHALL start a new image with freshly captured config.
REQ-022 Changes to config mid-image SHALL be ignored.
REQ-023 Each enabled skid stage SHALL be a 2-entry buffer that sustains one word per cycle under continuous valid/ready.
REQ-024 Latency from input acceptance to output_valid SHALL be LATCH_INPUT+LATCH_OUTPUT cycles. With both set to 0 the path is combinational.
REQ-025 Output data and flags SHALL be held stable while output_valid=1 and output_ready=0.
REQ-026 raw_input_ready SHALL deassert only when the internal stages are full.
REQ-027 If config_image_* equals 0 (a size of 1), that dimension SHALL be treated as a single-element dimension. All-zero config SHALL assert all four flags on every word.
REQ-028 When the block size exceeds the image size, the block SHALL be truncated to the image size.
REQ-029 No words SHALL be dropped or duplicated, and order SHALL be preserved.

Reset
REQ-030 With rst=1 at a clock edge: all counters = 0, skid stages empty, output_valid = 0, raw_input_ready = 0, all output_last_* = 0.
REQ-031 raw_input_ready SHALL assert on the first cycle after rst deasserts.
REQ-032 Reset asserted mid-image SHALL discard all buffered words. After reset, the first word of a new image SHALL follow.

Verification
REQ-033 Scenario 1: image 7x7x3, block 3x3, mode 0, ramp data 0..146, free-running drain.
  - Block 0 (indices 0..26): last_s at 2,5,...,26; last_r at 8,17,26; last_b at 26.
  - last_i only at index 146; exactly 147 outputs; data equals the ramp.
REQ-034 Scenario 2: same config as Scenario 1, mode 1.
  - Block 0: last_b at 2,5,...,26; last_s at 8,17,26; last_r at 26.
  - last_i at index 146.
REQ-035 Scenario 3: edge block at block column 2 (width 1) in mode 0.
  - last_s on every word of that block.
  - last_r every 3rd word, last_b on the 9th word.
REQ-036 Scenario 4: random valid and ready gaps (50% each), mode 0 config.
  - Output stream and flags are identical to Scenario 1.
  - Output is stable during stalls; no loss or duplication.
REQ-037 Scenario 5: change config_block_samples to 1 at word 40, then stream a second image.
  - Image 1 flags are unchanged from Scenario 1.
  - Image 2 uses block width 2 (last_s at 1,3,5,...).
REQ-038 Scenario 6: assert rst for 1 cycle at word 60, then restart.
  - output_valid=0 the cycle after reset.
  - The next outputs match Scenario 1 starting from index 0.
